baud_gen: RTL and testbench
===========================

Name: baud_gen

Overview:
Programmable baud-rate tick generator for the UART receive/transmit path. Derives a single-cycle oversampling strobe, baud_tick, from the system clock at an average rate of BAUD_RATE*OVERSAMPLE Hz. Sits between the system clock domain and the UART RX/TX bit-timing logic, which count baud_tick pulses.

Parameters:
CLK_FREQ, 25_000_000, system clock frequency in Hz.
BAUD_RATE, 115_200, serial bit rate in baud.
OVERSAMPLE, 16, ticks per bit period.
Derived, not overridable:
- STEP = BAUD_RATE*OVERSAMPLE (1_843_200 at defaults).
- DIV = CLK_FREQ/STEP, integer-truncated (13 at defaults).
- ACC_W = clog2(2*CLK_FREQ) (26 at defaults).

Ports:
sys_clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
baud_tick  output  1  registered strobe, high for exactly one sys_clk cycle per tick.

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset is synchronous and active-high, sampled on the sys_clk rising edge.
- While reset is high:
  - accumulator/counter cleared to 0.
  - baud_tick driven 0.
  - No tick is ever produced during reset.
- Reset asserted mid-operation:
  - Next edge clears state.
  - Any pending tick is discarded.
  - Timing restarts from zero after release.
- baud_tick is a registered output, never combinational. Back-to-back ticks are impossible when DIV >= 2.
- Fractional mode (BAUD_GEN_FRAC_EN defined): ACC_W-bit accumulator acc. Each non-reset edge, let sum = acc + STEP:
  - If sum >= CLK_FREQ: acc <= sum - CLK_FREQ, baud_tick <= 1.
  - Else: acc <= sum, baud_tick <= 0.
  - The comparison is unsigned and at least ACC_W bits wide, so no overflow.
  - Tick spacing alternates between DIV and DIV+1 cycles.
  - Long-term average is exact: exactly STEP ticks per CLK_FREQ cycles.
  - At defaults:
    - First tick is registered on the 14th edge after reset deasserts.
    - Gaps follow 14, 14, 13, ... as dictated by the accumulator.
    - Exactly 1152 ticks per 15625 cycles.
- Integer mode (macro undefined): counter cnt, width clog2(DIV). Each non-reset edge:
  - If cnt == DIV-1: cnt <= 0, baud_tick <= 1.
  - Else: cnt <= cnt+1, baud_tick <= 0.
  - Fixed period DIV cycles. First tick is registered on the DIVth edge (13th at defaults).
- Parameter legality:
  - Elaboration must fail with an error message if STEP > CLK_FREQ, or DIV < 1, or any parameter is 0.
  - DIV == 1 (integer mode) holds baud_tick permanently high after the first edge out of reset.
- No other outputs or status. Power-up state before the first reset is don't-care.

Optional Feature:
BAUD_GEN_FRAC_EN.
- Defined: fractional accumulator mode as above; exact average rate; jitter of at most one sys_clk cycle per tick.
- Undefined: plain integer divide-by-DIV counter; zero jitter; rate error (CLK_FREQ/DIV - STEP)/STEP. At defaults this is +4.3%, tick every 520 ns.
- Port list and reset behaviour are identical in both modes.

Test Plan:
- Reset held 5 cycles (200 ns at 40 ns period) -> baud_tick 0 throughout; no tick on the release edge.
- Integer mode, defaults, release reset -> first tick registered on the 13th edge; then one tick every 13 cycles; 19 ticks within 10 us; each tick exactly one cycle wide.
- BAUD_GEN_FRAC_EN, defaults -> first tick on the 14th edge; gap before the second tick 14 cycles, before the third 13 cycles; every gap is 13 or 14.
- BAUD_GEN_FRAC_EN, count ticks over 15625 cycles after reset -> exactly 1152. Integer mode over the same window -> 1201.
- Reset reasserted 5 cycles after a tick, held 3 cycles, then released -> no tick while reset is high; next tick exactly 13 (integer) or 14 (fractional) edges after release.
- Parameter override CLK_FREQ=1_000_000, BAUD_RATE=62_500, OVERSAMPLE=16 (STEP = CLK_FREQ) -> tick every cycle after the first edge out of reset in both modes. With BAUD_RATE=125_000 -> elaboration error.

Source files
------------

// File: rtl/baud_gen.sv
// rtl/baud_gen.sv - programmable baud-rate oversampling tick generator
// Optional feature macro: BAUD_GEN_FRAC_EN selects the fractional accumulator
// (exact average rate); when undefined a plain divide-by-DIV counter is built.
module baud_gen #(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic sys_clk,
  input  logic reset,
  output logic baud_tick
);

  // Tick rate in Hz and the integer clock division derived from it.
  localparam longint unsigned STEP = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
  localparam longint unsigned DIV  = (STEP == 0) ? 64'd0 : 64'(CLK_FREQ) / STEP;

  // Reject parameter sets that cannot produce a sensible strobe.
  if (CLK_FREQ == 0 || BAUD_RATE == 0 || OVERSAMPLE == 0) begin : g_err_zero
    $error("baud_gen: CLK_FREQ, BAUD_RATE and OVERSAMPLE must all be nonzero");
  end
  if (STEP > 64'(CLK_FREQ)) begin : g_err_step
    $error("baud_gen: BAUD_RATE*OVERSAMPLE exceeds CLK_FREQ");
  end
  if (DIV < 1) begin : g_err_div
    $error("baud_gen: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 1");
  end

`ifdef BAUD_GEN_FRAC_EN

  // Accumulator holds the phase remainder, always below CLK_FREQ; one extra
  // bit on the sum keeps acc + STEP from wrapping before the compare.
  localparam int ACC_W = (CLK_FREQ > 0) ? $clog2(2 * 64'(CLK_FREQ)) : 1;
  localparam logic [ACC_W:0] STEP_V = (ACC_W + 1)'(STEP);
  localparam logic [ACC_W:0] FREQ_V = (ACC_W + 1)'(CLK_FREQ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // Next phase before wrap-around.
  always_comb begin
    sum = {1'b0, acc} + STEP_V;
  end

  // Advance the phase by STEP each cycle; wrapping past CLK_FREQ emits a tick.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      acc       <= '0;
      baud_tick <= 1'b0;
    end else if (sum >= FREQ_V) begin
      acc       <= ACC_W'(sum - FREQ_V);
      baud_tick <= 1'b1;
    end else begin
      acc       <= sum[ACC_W-1:0];
      baud_tick <= 1'b0;
    end
  end

`else

  // DIV == 1 would give a zero-width counter, so keep at least one bit.
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running modulo-DIV counter; the terminal count emits a tick.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt       <= '0;
      baud_tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt       <= '0;
      baud_tick <= 1'b1;
    end else begin
      cnt       <= cnt + CNT_W'(1);
      baud_tick <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_baud_gen.sv
// tb/tb_baud_gen.sv - directed self-checking bench for baud_gen
module tb_baud_gen;

`ifdef BAUD_GEN_FRAC_EN
  localparam int FIRST_EDGE = 14;
  localparam int GAP2       = 14;
  localparam int GAP3       = 13;
  localparam int GAP_MIN    = 13;
  localparam int GAP_MAX    = 14;
  localparam int WIN_TICKS  = 1152;
  localparam int TICKS_10US = 18;
`else
  localparam int FIRST_EDGE = 13;
  localparam int GAP2       = 13;
  localparam int GAP3       = 13;
  localparam int GAP_MIN    = 13;
  localparam int GAP_MAX    = 13;
  localparam int WIN_TICKS  = 1201;
  localparam int TICKS_10US = 19;
`endif
  localparam int WINDOW = 15625;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  logic baud_tick;
  logic fast_tick;

  int n_checks = 0;
  int n_errors = 0;

  always #20 sys_clk = ~sys_clk;

  baud_gen dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .baud_tick (baud_tick)
  );

  baud_gen #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (62_500),
    .OVERSAMPLE (16)
  ) dut_fast (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .baud_tick (fast_tick)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  initial begin
    int edge_no;
    int first_e, second_e, third_e, last_e;
    int ticks, ticks_10us, fast_ticks, bad_gaps, wide_ticks;
    logic prev_tick;
    int wait_e;
    bit seen;

    // Reset held for 5 cycles: both instances stay quiet.
    @(negedge sys_clk);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val($sformatf("reset_tick_%0d", i), baud_tick, 0);
      check_val($sformatf("reset_fast_%0d", i), fast_tick, 0);
    end

    // Release and observe the full averaging window.
    reset = 1'b0;
    first_e = 0; second_e = 0; third_e = 0; last_e = 0;
    ticks = 0; ticks_10us = 0; fast_ticks = 0; bad_gaps = 0; wide_ticks = 0;
    prev_tick = 1'b0;
    for (edge_no = 1; edge_no <= WINDOW; edge_no++) begin
      step();
      if (edge_no == 1) check_val("fast_first_edge", fast_tick, 1);
      if (fast_tick === 1'b1) fast_ticks++;
      if (prev_tick === 1'b1 && baud_tick === 1'b1) wide_ticks++;
      if (baud_tick === 1'b1) begin
        ticks++;
        if (edge_no <= 250) ticks_10us++;
        if (ticks == 1) first_e = edge_no;
        else if (ticks == 2) second_e = edge_no;
        else if (ticks == 3) third_e = edge_no;
        if (last_e != 0 && (edge_no - last_e < GAP_MIN || edge_no - last_e > GAP_MAX))
          bad_gaps++;
        last_e = edge_no;
      end
      prev_tick = baud_tick;
    end
    check_val("first_tick_edge", first_e, FIRST_EDGE);
    check_val("gap_to_second", second_e - first_e, GAP2);
    check_val("gap_to_third", third_e - second_e, GAP3);
    check_val("ticks_in_10us", ticks_10us, TICKS_10US);
    check_val("ticks_in_window", ticks, WIN_TICKS);
    check_val("gaps_out_of_range", bad_gaps, 0);
    check_val("multi_cycle_ticks", wide_ticks, 0);
    check_val("fast_ticks_in_window", fast_ticks, WINDOW);

    // Wait for a tick, go 5 more cycles, then pulse reset for 3 cycles.
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (baud_tick === 1'b1) seen = 1'b1;
    end
    check_val("tick_before_midreset", seen, 1);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("midreset_tick_%0d", i), baud_tick, 0);
    end
    reset = 1'b0;
    wait_e = 0;
    for (int i = 1; i <= 40 && wait_e == 0; i++) begin
      step();
      if (baud_tick === 1'b1) wait_e = i;
    end
    check_val("tick_after_midreset", wait_e, FIRST_EDGE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
